// File: rtl/barret_inv_383.sv
// GF(383) modular inverse by Fermat exponentiation (a^381 mod 383).
// It uses left-to-right square-and-multiply around one multiplier and an 18-bit Barrett reducer.
module barret_inv_383 #(
  parameter int Q   = 383,
  parameter int K   = 9,
  parameter int MU  = 684,
  parameter int EXP = 381
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] din_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] dout_r,
  output logic         dout_zero
);

  localparam int PW = 2 * K;
  localparam int QW = PW + 2;
  localparam int IW = $clog2(K);
  localparam logic [K-1:0]  QK   = K'(Q);
  localparam logic [PW-1:0] QP   = PW'(Q);
  localparam logic [QW-1:0] MUW  = QW'(MU);
  localparam logic [K-1:0]  EXPV = K'(EXP);

  typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_DONE} state_t;

  // Barrett: the quotient estimate undershoots by at most 2, so two corrective subtractions suffice
  function automatic logic [K-1:0] red(input logic [PW-1:0] x);
    logic [QW-1:0] q1mu;
    logic [K:0]    t;
    logic [PW-1:0] tq;
    logic [PW-1:0] r;
    q1mu = QW'(x >> (K - 1)) * MUW;
    t    = q1mu[QW-1:K+1];
    tq   = PW'(t) * QP;
    r    = x - tq;
    if (r >= QP) r = r - QP;
    if (r >= QP) r = r - QP;
    return r[K-1:0];
  endfunction

  state_t          r_state;
  logic [K-1:0]    r_a;
  logic [K-1:0]    r_acc;
  logic [IW-1:0]   r_idx;
  logic            r_zflag;

  logic [K-1:0]    w_a_prep;
  logic [K-1:0]    w_mul_op;
  logic [PW-1:0]   w_prod;
  logic [K-1:0]    w_red;

  assign w_a_prep = (din_a >= QK) ? din_a - QK : din_a;
  assign w_mul_op = (r_state == S_MUL) ? r_a : r_acc;
  assign w_prod   = PW'(r_acc) * PW'(w_mul_op);
  assign w_red    = red(w_prod);
  assign in_ready = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_acc     <= K'(1);
      r_idx     <= IW'(K - 1);
      r_zflag   <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= w_a_prep;
            r_zflag <= (w_a_prep == '0);
            r_acc   <= K'(1);
            r_idx   <= IW'(K - 1);
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          r_acc <= w_red;
          if (EXPV[r_idx]) begin
            r_state <= S_MUL;
          end else if (r_idx == '0) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_MUL: begin
          r_acc <= w_red;
          if (r_idx == '0) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= S_SQR;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; it is then held until the consumer takes it
          if (!out_valid) begin
            out_valid <= 1'b1;
            dout_r    <= r_acc;
            dout_zero <= r_zflag;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barret_inv_383.sv
// Directed and exhaustive checks of the GF(383) inverse: the bench covers latency, input prep,
// the zero operand, backpressure and a mid-operation reset.
module tb_barret_inv_383;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] din_a;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] dout_r;
  logic       dout_zero;

  int nchk = 0;
  int nerr = 0;

  barret_inv_383 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .dout_zero (dout_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [8:0] din;
    logic [8:0] exp_r;
    logic       exp_z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [8:0] v);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("accept_ready", int'(in_ready), 1);
    din_a    = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din_a    = 9'h1FF;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", int'(out_valid), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [8:0] v, output logic [8:0] r, output logic z, output int lat);
    start_op(v);
    wait_done(lat);
    r = dout_r;
    z = dout_zero;
    handshake();
  endtask

  initial begin
    vec_t       tbl [10];
    logic [8:0] r;
    logic       z;
    int         lat;
    int         seen;

    tbl[0] = '{din: 9'd1,   exp_r: 9'd1,   exp_z: 1'b0};
    tbl[1] = '{din: 9'd2,   exp_r: 9'd192, exp_z: 1'b0};
    tbl[2] = '{din: 9'd382, exp_r: 9'd382, exp_z: 1'b0};
    tbl[3] = '{din: 9'd384, exp_r: 9'd1,   exp_z: 1'b0};
    tbl[4] = '{din: 9'd0,   exp_r: 9'd0,   exp_z: 1'b1};
    tbl[5] = '{din: 9'd383, exp_r: 9'd0,   exp_z: 1'b1};
    tbl[6] = '{din: 9'd511, exp_r: 9'd3,   exp_z: 1'b0};
    tbl[7] = '{din: 9'd3,   exp_r: 9'd128, exp_z: 1'b0};
    tbl[8] = '{din: 9'd5,   exp_r: 9'd230, exp_z: 1'b0};
    tbl[9] = '{din: 9'd6,   exp_r: 9'd64,  exp_z: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din_a     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout_r",    int'(dout_r),    0);
    chk("rst_dout_zero", int'(dout_zero), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    rst_n = 1'b1;

    // out_ready asserted with nothing pending has no effect
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_oready_valid", int'(out_valid), 0);
    chk("idle_oready_ready", int'(in_ready),  1);
    out_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].din, r, z, lat);
      chk($sformatf("tbl%0d_r", i),   int'(r), int'(tbl[i].exp_r));
      chk($sformatf("tbl%0d_z", i),   int'(z), int'(tbl[i].exp_z));
      chk($sformatf("tbl%0d_lat", i), lat, 17);
      chk($sformatf("tbl%0d_release", i), int'(out_valid), 0);
    end

    // Backpressure: result held for 10 cycles while in_valid pulses are refused
    start_op(9'd2);
    wait_done(lat);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      din_a    = 9'd11;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), int'(out_valid), 1);
      chk($sformatf("bp%0d_r", c),     int'(dout_r),    192);
      chk($sformatf("bp%0d_ready", c), int'(in_ready),  0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_after_valid", int'(out_valid), 0);
    chk("bp_after_ready", int'(in_ready),  1);
    do_op(9'd4, r, z, lat);
    chk("bp_next_r", int'(r), 96);

    // Reset in the middle of a computation aborts it
    start_op(9'd9);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(in_ready),  1);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    do_op(9'd5, r, z, lat);
    chk("midrst_next_r",   int'(r), 230);
    chk("midrst_next_lat", lat, 17);

    for (int a = 1; a < 383; a++) begin
      do_op(9'(a), r, z, lat);
      chk($sformatf("inv_a%0d", a), (a * int'(r)) % 383, 1);
      if (z) chk($sformatf("inv_z%0d", a), int'(z), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
